// File: rtl/latch_write_scheduler.sv
// Round-robin scheduler sharing one external D-latch bank among requesters.
// Drives D/E through a setup, enable-pulse, hold sequence with registered outputs.
module latch_write_scheduler #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [DATA_W-1:0]       D,
    output logic                    E,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        ack,
    output logic                    busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_C = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CNT_W = $clog2(MAX_C) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [PTR_W-1:0]   idx, idx_n;
    logic [PTR_W-1:0]   rr_ptr, rr_n;
    logic [DATA_W-1:0]  d_n;
    logic               e_n;
    logic [N_REQ-1:0]   grant_n;
    logic [N_REQ-1:0]   ack_n;
    logic               busy_n;
    logic               found;
    logic [PTR_W-1:0]   pick;

    // Round-robin search: first pending requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = PTR_W'(j);
            end
        end
    end

    // Next-state and next-output logic; everything lands in registers.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        rr_n    = rr_ptr;
        d_n     = D;
        e_n     = E;
        grant_n = grant;
        ack_n   = '0;
        busy_n  = busy;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n       = SETUP;
                    idx_n         = pick;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    d_n           = data_in[int'(pick)*DATA_W +: DATA_W];
                    busy_n        = 1'b1;
                    cnt_n         = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    e_n     = 1'b1;
                    cnt_n   = CNT_W'(PULSE_CYC - 1);
                    state_n = ENABLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ENABLE: begin
                if (cnt == '0) begin
                    e_n     = 1'b0;
                    cnt_n   = CNT_W'(HOLD_CYC - 1);
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                ack_n   = grant;
                rr_n    = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + PTR_W'(1);
                grant_n = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any write and drops E at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            rr_ptr <= '0;
            D      <= '0;
            E      <= 1'b0;
            grant  <= '0;
            ack    <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            rr_ptr <= rr_n;
            D      <= d_n;
            E      <= e_n;
            grant  <= grant_n;
            ack    <= ack_n;
            busy   <= busy_n;
        end
    end

endmodule

// File: tb/tb_latch_write_scheduler.sv
// Self-checking bench for latch_write_scheduler: vector table, corner sequences,
// and random stimulus against a transaction-level reference model.
module tb_latch_write_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] data_in = '0;

    logic [7:0]  d1, d2;
    logic        e1, e2;
    logic [3:0]  g1, g2, a1, a2;
    logic        b1, b2;

    int total = 0;
    int bad   = 0;
    bit mchk  = 1'b0;

    always #5 clk = ~clk;

    latch_write_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .D(d1), .E(e1), .grant(g1), .ack(a1), .busy(b1)
    );

    latch_write_scheduler #(
        .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)
    ) dut2 (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .D(d2), .E(e2), .grant(g2), .ack(a2), .busy(b2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction is a run of cycle offsets t from the
    // grant edge; E is high for offsets [S, S+P), ack lands at S+P+H+1.
    typedef struct {
        bit         act;
        int         t;
        int         ptr;
        int         idx;
        logic [7:0] d;
        logic [3:0] ack;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t m;
        m.act = 0; m.t = 0; m.ptr = 0; m.idx = 0; m.d = '0; m.ack = '0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int s, int p, int h,
                                   logic [3:0] r, logic [31:0] di);
        mdl_t n;
        bit   got;
        n     = m;
        n.ack = '0;
        got   = 0;
        if (!m.act) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m.ptr + k) % 4;
                if (!got && r[j]) begin
                    got   = 1;
                    n.idx = j;
                end
            end
            if (got) begin
                n.act = 1;
                n.t   = 0;
                n.d   = di[n.idx*8 +: 8];
            end
        end else begin
            n.t = m.t + 1;
            if (n.t == s + p + h + 1) begin
                n.act = 0;
                n.ack = 4'b0001 << m.idx;
                n.ptr = (m.idx + 1) % 4;
            end
        end
        return n;
    endfunction

    mdl_t m1, m2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 <= mreset();
            m2 <= mreset();
        end else begin
            m1 <= mstep(m1, 1, 2, 1, req, data_in);
            m2 <= mstep(m2, 3, 1, 2, req, data_in);
        end
    end

    always @(negedge clk) begin
        if (mchk && !rst) begin
            chk("m1_E", 32'(e1), 32'(m1.act && m1.t >= 1 && m1.t < 3));
            chk("m1_D", 32'(d1), 32'(m1.d));
            chk("m1_grant", 32'(g1), m1.act ? 32'(4'b0001 << m1.idx) : 32'd0);
            chk("m1_ack", 32'(a1), 32'(m1.ack));
            chk("m1_busy", 32'(b1), 32'(m1.act));
            chk("m2_E", 32'(e2), 32'(m2.act && m2.t >= 3 && m2.t < 4));
            chk("m2_D", 32'(d2), 32'(m2.d));
            chk("m2_grant", 32'(g2), m2.act ? 32'(4'b0001 << m2.idx) : 32'd0);
            chk("m2_ack", 32'(a2), 32'(m2.ack));
            chk("m2_busy", 32'(b2), 32'(m2.act));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = '0;
        data_in = '0;
        rst     = 1'b1;
        tick();
        chk("rst_E", 32'(e1), 0);
        chk("rst_D", 32'(d1), 0);
        chk("rst_grant", 32'(g1), 0);
        chk("rst_ack", 32'(a1), 0);
        chk("rst_busy", 32'(b1), 0);
        tick();
        rst = 1'b0;
    endtask

    int gi[8];
    int gc[8];
    int ng;

    task automatic collect(input int n, input int budget);
        logic [3:0] prev;
        int         run;
        prev = g1;
        run  = 0;
        ng   = 0;
        for (int i = 0; i < 8; i++) begin
            gi[i] = -1;
            gc[i] = -100;
        end
        for (int c = 0; c < budget && ng < n; c++) begin
            tick();
            if (prev == 4'b0 && g1 != 4'b0) begin
                gi[ng] = $clog2(g1);
                gc[ng] = c;
                chk("grant_D", 32'(d1), 32'(data_in[gi[ng]*8 +: 8]));
                ng++;
            end
            if (e1) begin
                run++;
            end else if (run != 0) begin
                chk("e_width", run, 2);
                run = 0;
            end
            prev = g1;
        end
        chk("n_grants", ng, n);
    endtask

    typedef struct {
        logic [3:0]  r;
        logic [31:0] d;
        logic [3:0]  g;
        logic [7:0]  dv;
    } vec_t;

    vec_t tv[5];

    initial begin
        tv[0] = '{r: 4'b0010, d: 32'h0000A500, g: 4'b0010, dv: 8'hA5};
        tv[1] = '{r: 4'b1100, d: 32'h44332211, g: 4'b0100, dv: 8'h33};
        tv[2] = '{r: 4'b1000, d: 32'hC3000000, g: 4'b1000, dv: 8'hC3};
        tv[3] = '{r: 4'b1111, d: 32'hDEADBEEF, g: 4'b0001, dv: 8'hEF};
        tv[4] = '{r: 4'b1010, d: 32'h00005A00, g: 4'b0010, dv: 8'h5A};

        do_reset();
        mchk = 1'b1;

        for (int v = 0; v < 5; v++) begin
            do_reset();
            req     = tv[v].r;
            data_in = tv[v].d;
            tick();
            chk("v_grant", 32'(g1), 32'(tv[v].g));
            chk("v_setup_D", 32'(d1), 32'(tv[v].dv));
            chk("v_setup_E", 32'(e1), 0);
            chk("v_busy", 32'(b1), 1);
            tick();
            chk("v_E1", 32'(e1), 1);
            tick();
            chk("v_E2", 32'(e1), 1);
            chk("v_pulse_D", 32'(d1), 32'(tv[v].dv));
            tick();
            chk("v_hold_E", 32'(e1), 0);
            chk("v_hold_D", 32'(d1), 32'(tv[v].dv));
            tick();
            chk("v_done_ack", 32'(a1), 0);
            tick();
            chk("v_ack", 32'(a1), 32'(tv[v].g));
            chk("v_idle_grant", 32'(g1), 0);
            chk("v_idle_busy", 32'(b1), 0);
            req = '0;
            tick();
            chk("v_ack_clear", 32'(a1), 0);
        end

        do_reset();
        req     = 4'b0010;
        data_in = 32'h0000A500;
        tick();
        tick();
        chk("abort_pre_E", 32'(e1), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_E", 32'(e1), 0);
        chk("abort_grant", 32'(g1), 0);
        chk("abort_busy", 32'(b1), 0);
        req = '0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("abort_no_ack", 32'(a1), 0);
        end

        do_reset();
        req     = 4'b1111;
        data_in = 32'h13121110;
        collect(5, 40);
        for (int i = 0; i < 5; i++) chk("rr_order", gi[i], i % 4);
        for (int i = 1; i < 5; i++) chk("rr_spacing", gc[i] - gc[i-1], 6);

        do_reset();
        req     = 4'b1000;
        data_in = 32'h99000088;
        tick();
        chk("wrap_first", 32'(g1), 32'(4'b1000));
        req = 4'b1001;
        collect(2, 20);
        chk("wrap_next0", gi[0], 0);
        chk("wrap_then3", gi[1], 3);

        do_reset();
        req     = 4'b0001;
        data_in = 32'h0000005A;
        tick();
        req     = 4'b0000;
        data_in = 32'h000000FF;
        tick();
        chk("drop_E1", 32'(e1), 1);
        chk("drop_D", 32'(d1), 32'h5A);
        tick();
        chk("drop_E2", 32'(e1), 1);
        tick();
        chk("drop_hold_E", 32'(e1), 0);
        chk("drop_hold_D", 32'(d1), 32'h5A);
        tick();
        tick();
        chk("drop_ack", 32'(a1), 32'(4'b0001));

        do_reset();
        req     = 4'b0100;
        data_in = 32'h00770000;
        tick();
        chk("p_grant", 32'(g2), 32'(4'b0100));
        chk("p_D0", 32'(d2), 32'h77);
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk("p_E", 32'(e2), 32'(t == 3));
            chk("p_D", 32'(d2), 32'h77);
            chk("p_ack", 32'(a2), (t == 7) ? 32'(4'b0100) : 32'd0);
        end
        req = '0;

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req     = 4'($urandom);
            data_in = $urandom;
            if ($urandom_range(0, 249) == 0) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
